// File: rtl/lpddr4_rddata_aligner.sv
// LPDDR4 DFI read-return aligner: lane compaction, FWFT word FIFO, credit and error flags.
// Optional return timeout enabled by defining LPDDR4_RDDATA_TIMEOUT_EN.
module lpddr4_rddata_aligner #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         dfi_p0_rddata_en,
    input  logic         dfi_p1_rddata_en,
    input  logic         dfi_p2_rddata_en,
    input  logic         dfi_p3_rddata_en,
    input  logic [63:0]  dfi_p0_rddata,
    input  logic [63:0]  dfi_p1_rddata,
    input  logic [63:0]  dfi_p2_rddata,
    input  logic [63:0]  dfi_p3_rddata,
    input  logic         dfi_p0_rddata_valid,
    input  logic         dfi_p1_rddata_valid,
    input  logic         dfi_p2_rddata_valid,
    input  logic         dfi_p3_rddata_valid,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [255:0] rd_data,
    output logic         rd_credit_ok,
    input  logic         err_clr,
    output logic         err_unexpected,
    output logic         err_overflow,
    output logic         err_timeout
);
    localparam int OW = $clog2(4 * DEPTH + 1) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = OW + 2;

    logic [3:0]  en_vec;
    logic [3:0]  vld_vec;
    logic [63:0] ph_data [4];
    logic [2:0]  en_cnt;
    logic [2:0]  vld_cnt;

    assign en_vec  = {dfi_p3_rddata_en, dfi_p2_rddata_en,
                      dfi_p1_rddata_en, dfi_p0_rddata_en};
    assign vld_vec = {dfi_p3_rddata_valid, dfi_p2_rddata_valid,
                      dfi_p1_rddata_valid, dfi_p0_rddata_valid};
    assign ph_data[0] = dfi_p0_rddata;
    assign ph_data[1] = dfi_p1_rddata;
    assign ph_data[2] = dfi_p2_rddata;
    assign ph_data[3] = dfi_p3_rddata;

    assign en_cnt  = {2'b0, en_vec[0]} + {2'b0, en_vec[1]}
                   + {2'b0, en_vec[2]} + {2'b0, en_vec[3]};
    assign vld_cnt = {2'b0, vld_vec[0]} + {2'b0, vld_vec[1]}
                   + {2'b0, vld_vec[2]} + {2'b0, vld_vec[3]};

    // Outstanding lane accounting
    logic [OW-1:0] outst;
    logic [OW-1:0] outst_nxt;
    logic [OW:0]   demand;
    logic          unexpected;

    assign demand     = {1'b0, outst} + (OW + 1)'(en_cnt);
    assign unexpected = (OW + 1)'(vld_cnt) > demand;
    assign outst_nxt  = unexpected ? '0
                      : OW'(demand - (OW + 1)'(vld_cnt));

    // Lane compaction into the assembly register
    logic [1:0]   held;
    logic [1:0]   held_nxt;
    logic [63:0]  asm_q   [3];
    logic [63:0]  asm_nxt [3];
    logic [63:0]  packed_l [4];
    logic [63:0]  comb_l   [8];
    logic [2:0]   idx;
    logic [2:0]   pos;
    logic [2:0]   total;
    logic         word_done;
    logic [255:0] word;

    assign total     = {1'b0, held} + vld_cnt;
    assign word_done = total[2];
    assign held_nxt  = total[1:0];

    always_comb begin
        for (int p = 0; p < 4; p++) packed_l[p] = '0;
        for (int i = 0; i < 8; i++) comb_l[i] = '0;
        idx = '0;
        pos = '0;
        for (int p = 0; p < 4; p++) begin
            if (vld_vec[p]) begin
                packed_l[idx[1:0]] = ph_data[p];
                idx = idx + 3'd1;
            end
        end
        for (int h = 0; h < 3; h++) begin
            if (2'(h) < held) comb_l[h] = asm_q[h];
        end
        for (int j = 0; j < 4; j++) begin
            pos = {1'b0, held} + 3'(j);
            if (3'(j) < vld_cnt) comb_l[pos] = packed_l[j];
        end
        word = {comb_l[3], comb_l[2], comb_l[1], comb_l[0]};
        for (int h = 0; h < 3; h++) begin
            asm_nxt[h] = word_done ? comb_l[h + 4] : comb_l[h];
        end
    end

    // First-word-fall-through FIFO
    logic [255:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf;

    assign full     = cnt == CW'(DEPTH);
    assign rd_valid = cnt != '0;
    assign rd_data  = rd_valid ? mem[rp] : '0;
    assign pop      = rd_valid && rd_ready;
    assign push     = word_done && (!full || pop);
    assign ovf      = word_done && full && !pop;

    always_ff @(posedge sys_clk) begin
        if (push) mem[wp] <= word;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            outst <= '0;
            held  <= '0;
            for (int h = 0; h < 3; h++) asm_q[h] <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
            outst <= outst_nxt;
            held  <= held_nxt;
            for (int h = 0; h < 3; h++) asm_q[h] <= asm_nxt[h];
        end
    end

    // Credit counts FIFO space still unclaimed by requested or held lanes
    logic [CW-1:0] free_w;
    logic [LW-1:0] cap;
    logic [LW-1:0] need;

    assign free_w       = CW'(DEPTH) - cnt;
    assign cap          = LW'({free_w, 2'b00});
    assign need         = LW'(outst) + LW'(held) + LW'(4);
    assign rd_credit_ok = cap >= need;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
        end else if (err_clr) begin
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            if (unexpected) err_unexpected <= 1'b1;
            if (ovf)        err_overflow   <= 1'b1;
        end
    end

`ifdef LPDDR4_RDDATA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_nxt;
    logic          to_hit;

    always_comb begin
        to_nxt = to_cnt;
        if (outst == '0 || vld_cnt != '0)
            to_nxt = '0;
        else if (to_cnt != TW'(TIMEOUT_CYCLES))
            to_nxt = to_cnt + TW'(1);
    end

    assign to_hit = to_nxt == TW'(TIMEOUT_CYCLES);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            to_cnt <= to_nxt;
            if (err_clr)     err_timeout <= 1'b0;
            else if (to_hit) err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lpddr4_rddata_aligner.sv
// Randomized scoreboard bench for lpddr4_rddata_aligner.
// Reference model: lane queue plus word-FIFO occupancy; timeout modelled when LPDDR4_RDDATA_TIMEOUT_EN.
module tb_lpddr4_rddata_aligner;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic         clk = 0;
    logic         rst = 1;
    logic [3:0]   en  = '0;
    logic [3:0]   vld = '0;
    logic [63:0]  d [4];
    logic         rdy = 0;
    logic         clr = 0;
    logic         rd_valid;
    logic [255:0] rd_data;
    logic         rd_credit_ok;
    logic         err_unexpected;
    logic         err_overflow;
    logic         err_timeout;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [255:0] exp_q [$];
    logic [63:0]  lq [$];
    int           m_outst = 0;
    int           m_occ   = 0;
    int           m_idle  = 0;
    logic         m_unexp = 0;
    logic         m_ovf   = 0;
    logic         m_tmo   = 0;

    always #5 clk = ~clk;

    lpddr4_rddata_aligner #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .dfi_p0_rddata_en(en[0]),
        .dfi_p1_rddata_en(en[1]),
        .dfi_p2_rddata_en(en[2]),
        .dfi_p3_rddata_en(en[3]),
        .dfi_p0_rddata(d[0]),
        .dfi_p1_rddata(d[1]),
        .dfi_p2_rddata(d[2]),
        .dfi_p3_rddata(d[3]),
        .dfi_p0_rddata_valid(vld[0]),
        .dfi_p1_rddata_valid(vld[1]),
        .dfi_p2_rddata_valid(vld[2]),
        .dfi_p3_rddata_valid(vld[3]),
        .rd_valid(rd_valid),
        .rd_ready(rdy),
        .rd_data(rd_data),
        .rd_credit_ok(rd_credit_ok),
        .err_clr(clr),
        .err_unexpected(err_unexpected),
        .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    function automatic int pc(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    function automatic logic m_credit();
        return (4 * (DEPTH - m_occ) - m_outst - lq.size()) >= 4;
    endfunction

    task automatic cmp(input string name, input logic [255:0] act,
                       input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state();
        cmp("rd_valid", 256'(rd_valid), 256'(m_occ > 0));
        cmp("credit", 256'(rd_credit_ok), 256'(m_credit()));
        cmp("err_unexpected", 256'(err_unexpected), 256'(m_unexp));
        cmp("err_overflow", 256'(err_overflow), 256'(m_ovf));
        cmp("err_timeout", 256'(err_timeout), 256'(m_tmo));
        if (!rd_valid) cmp("rd_data_idle", rd_data, '0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        lq.delete();
        m_outst = 0;
        m_occ   = 0;
        m_idle  = 0;
        m_unexp = 0;
        m_ovf   = 0;
        m_tmo   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic step(input logic [3:0] e, input logic [3:0] v,
                        input logic r, input logic c);
        int ec, vc, prev_outst;
        logic pop, set_u, set_o, set_t;
        en  = e;
        vld = v;
        rdy = r;
        clr = c;
        for (int p = 0; p < 4; p++) d[p] = {$urandom, $urandom};
        ec = pc(e);
        vc = pc(v);
        prev_outst = m_outst;
        set_u = vc > m_outst + ec;
        m_outst = set_u ? 0 : m_outst + ec - vc;
        for (int p = 0; p < 4; p++) if (v[p]) lq.push_back(d[p]);
        pop = (m_occ > 0) && r;
        set_o = 0;
        if (lq.size() >= 4) begin
            logic [255:0] w;
            w = {lq[3], lq[2], lq[1], lq[0]};
            repeat (4) void'(lq.pop_front());
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back(w);
                m_occ++;
            end else begin
                set_o = 1;
            end
        end
        if (pop) m_occ--;
        if (prev_outst > 0 && vc == 0) begin
            if (m_idle < TMO) m_idle++;
        end else begin
            m_idle = 0;
        end
`ifdef LPDDR4_RDDATA_TIMEOUT_EN
        set_t = m_idle == TMO;
`else
        set_t = 0;
`endif
        if (c) begin
            m_unexp = 0;
            m_ovf   = 0;
            m_tmo   = 0;
        end else begin
            if (set_u) m_unexp = 1;
            if (set_o) m_ovf   = 1;
            if (set_t) m_tmo   = 1;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (!rst && rd_valid && rdy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_unexpected: got %0h want none", rd_data);
            end else begin
                logic [255:0] w;
                w = exp_q.pop_front();
                if (rd_data !== w) begin
                    bad++;
                    $display("FAIL word: got %0h want %0h", rd_data, w);
                end
            end
        end
    end

    initial begin
        int issued;
        for (int p = 0; p < 4; p++) d[p] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_state();
        cmp("rst_credit", 256'(rd_credit_ok), 256'(1));
        rst = 0;

        // Aligned return
        step(4'b1111, 4'b0000, 1, 0);
        step(4'b0000, 4'b0000, 1, 0);
        step(4'b0000, 4'b0000, 1, 0);
        step(4'b0000, 4'b1111, 1, 0);
        step(4'b0000, 4'b0000, 1, 0);

        // Phase-shifted return
        step(4'b1111, 4'b0000, 1, 0);
        step(4'b0000, 4'b1100, 1, 0);
        step(4'b0000, 4'b0011, 1, 0);
        step(4'b0000, 4'b0000, 1, 0);

        // Fill and credit
        issued = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_credit()) begin
                issued++;
                step(4'b1111, 4'b0000, 0, 0);
            end else begin
                step(4'b0000, 4'b0000, 0, 0);
            end
        end
        cmp("fill_issued", 256'(issued), 256'(DEPTH));
        repeat (DEPTH) step(4'b0000, 4'b1111, 0, 0);
        cmp("fill_full", 256'(rd_valid), 256'(1));
        repeat (DEPTH + 2) step(4'b0000, 4'b0000, 1, 0);

        // Forced overflow then clear
        repeat (DEPTH + 1) step(4'b1111, 4'b1111, 0, 0);
        cmp("ovf_set", 256'(err_overflow), 256'(1));
        step(4'b0000, 4'b0000, 0, 1);
        cmp("ovf_clr", 256'(err_overflow), 256'(0));
        repeat (DEPTH + 2) step(4'b0000, 4'b0000, 1, 0);

        // Unexpected return
        step(4'b0000, 4'b0001, 1, 0);
        cmp("unexp_set", 256'(err_unexpected), 256'(1));
        step(4'b0000, 4'b0000, 1, 1);

        // Timeout window
        step(4'b1111, 4'b0000, 1, 0);
        repeat (TMO + 6) step(4'b0000, 4'b0000, 1, 0);
`ifdef LPDDR4_RDDATA_TIMEOUT_EN
        cmp("tmo_set", 256'(err_timeout), 256'(1));
`else
        cmp("tmo_off", 256'(err_timeout), 256'(0));
`endif
        step(4'b0000, 4'b1111, 1, 1);

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] e, v;
            if (i == 800) begin
                rst = 1;
                en = '0;
                vld = '0;
                model_reset();
                #1;
                check_state();
                @(posedge clk);
                #1;
                rst = 0;
            end
            e = m_credit() ? 4'($urandom_range(0, 15)) : 4'b0000;
            v = 4'($urandom_range(0, 15));
            if (pc(v) > m_outst + pc(e) && $urandom_range(0, 19) != 0)
                v = '0;
            step(e, v, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            step(4'b0000, 4'b0000, 1, 0);
        cmp("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
